// File: rtl/cpu_div_pkg.sv
// Shared types and constants for the EXE-stage sequential divider.
package cpu_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DATA_W_DEF = 32;

    // Quotient written for a zero divisor.
    localparam logic [DATA_W_DEF-1:0] DIV0_LO = '1;

endpackage

// File: rtl/exe_div_seq_ctrl_if.sv
// Pipeline-side handshake of the divide sequencer: ID/EXE fields in, stall and HI/LO write out.
interface exe_div_seq_ctrl_if #(parameter int DATA_W = 32);

    logic              ex_is_div;
    logic              ex_is_sign_div;
    logic [DATA_W-1:0] ex_src0;
    logic [DATA_W-1:0] ex_src1;
    logic              irq;
    logic              stall_other;
    logic              stall_div;
    logic              busy;
    logic              hilo_we;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;

    modport master (
        output ex_is_div, ex_is_sign_div, ex_src0, ex_src1, irq, stall_other,
        input  stall_div, busy, hilo_we, hi_o, lo_o
    );

    modport slave (
        input  ex_is_div, ex_is_sign_div, ex_src0, ex_src1, irq, stall_other,
        output stall_div, busy, hilo_we, hi_o, lo_o
    );

endinterface

// File: rtl/exe_div_seq_ctrl_div_iter.sv
// Radix-2 restoring unsigned divider, one quotient bit per step.
// quot/rem present the result of the step taken this cycle, so the caller can capture the final step directly.
module div_iter_unsigned
    import cpu_div_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] quot,
    output logic [DATA_W-1:0] rem
);

    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] q_q;
    logic [DATA_W-1:0] d_q;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   diff;
    logic              fits;

    // Partial remainder is one bit wider so the trial subtract's borrow lands in the MSB.
    assign shifted = {r_q, q_q[DATA_W-1]};
    assign diff    = shifted - {1'b0, d_q};
    assign fits    = ~diff[DATA_W];
    assign quot    = {q_q[DATA_W-2:0], fits};
    assign rem     = fits ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
            q_q <= '0;
            d_q <= '0;
        end else if (load) begin
            r_q <= '0;
            q_q <= a;
            d_q <= b;
        end else if (step) begin
            r_q <= rem;
            q_q <= quot;
        end
    end

endmodule

// File: rtl/exe_div_seq_ctrl.sv
// DIV/DIVU sequencer for EXE: holds the divide in ID/EXE via stall_div, runs the
// unsigned engine on magnitudes, fixes up signs and strobes HI/LO once.
module exe_div_seq_ctrl
    import cpu_div_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input logic                clk,
    input logic                rst_n,
    exe_div_seq_ctrl_if.slave  dif
);

    localparam int              CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W);

    div_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] a_abs;
    logic [DATA_W-1:0] b_abs;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] quot;
    logic [DATA_W-1:0] rem;
    logic              neg_q;
    logic              neg_r;
    logic              we_q;
    logic              sign0;
    logic              sign1;
    logic              start;
    logic              load;
    logic              step;

    assign sign0 = dif.ex_is_sign_div & dif.ex_src0[DATA_W-1];
    assign sign1 = dif.ex_is_sign_div & dif.ex_src1[DATA_W-1];
    assign start = (state == IDLE) & dif.ex_is_div & ~dif.irq;
    assign load  = (state == RUN) & (cnt == '0);
    assign step  = (state == RUN) & (cnt != '0);

    // irq flushes ID/EXE, so the stall and any pending write must drop in the same cycle.
    assign dif.stall_div = (((state == IDLE) & dif.ex_is_div) | (state == RUN)) & ~dif.irq;
    assign dif.hilo_we   = we_q & ~dif.irq;
    assign dif.busy      = (state != IDLE);
    assign dif.hi_o      = hi_q;
    assign dif.lo_o      = lo_q;

    div_iter_unsigned #(.DATA_W(DATA_W)) u_iter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .step  (step),
        .a     (a_abs),
        .b     (b_abs),
        .quot  (quot),
        .rem   (rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            a_abs <= '0;
            b_abs <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            we_q  <= 1'b0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            we_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (dif.ex_src1 != '0) begin
                            a_abs <= sign0 ? -dif.ex_src0 : dif.ex_src0;
                            b_abs <= sign1 ? -dif.ex_src1 : dif.ex_src1;
                            neg_q <= sign0 ^ sign1;
                            neg_r <= sign0;
                            cnt   <= '0;
                            state <= RUN;
                        end else begin
                            hi_q  <= dif.ex_src0;
                            lo_q  <= {DATA_W{DIV0_LO[0]}};
                            we_q  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (dif.irq) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (cnt == LAST) begin
                        hi_q  <= neg_r ? -rem : rem;
                        lo_q  <= neg_q ? -quot : quot;
                        we_q  <= 1'b1;
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    // The divide is still held in ID/EXE while stall_other is up; don't restart it.
                    if (dif.irq || !dif.stall_other)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exe_div_seq_ctrl.sv
// Directed bench for exe_div_seq_ctrl: latency, results, divide-by-zero, irq abort, DONE hold, async reset.
module tb_exe_div_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    exe_div_seq_ctrl_if #(.DATA_W(32)) dif ();

    exe_div_seq_ctrl #(.DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dif   (dif.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        else n_pass++;
    endtask

    // Drives one divide from the current cycle (entered just after a rising edge) until it leaves EXE.
    task automatic run_div(input string tag, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                           input int exp_stall, input int so_hold, input bit tail);
        int n_st = 0;
        int n_we = 0;
        int we_at = -1;
        bit done = 0;
        dif.ex_is_div      = 1'b1;
        dif.ex_is_sign_div = sgn;
        dif.ex_src0        = a;
        dif.ex_src1        = b;
        for (int c = 0; c < 100 && !done; c++) begin
            dif.stall_other = (so_hold > 0) && (c >= exp_stall) && (c < exp_stall + so_hold);
            @(negedge clk);
            if (dif.stall_div) n_st++;
            if (dif.hilo_we) begin n_we++; we_at = c; end
            if (!dif.stall_div && !dif.stall_other) done = 1;
            @(posedge clk); #1;
        end
        dif.stall_other = 1'b0;
        if (tail) begin
            dif.ex_is_div = 1'b0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (dif.stall_div) n_st++;
                if (dif.hilo_we) n_we++;
                @(posedge clk); #1;
            end
        end
        chk({tag, " done"},  32'(done), 32'd1);
        chk({tag, " stall"}, 32'(n_st), 32'(exp_stall));
        chk({tag, " we_n"},  32'(n_we), 32'd1);
        chk({tag, " we_at"}, 32'(we_at), 32'(exp_stall));
        chk({tag, " hi"},    dif.hi_o, exp_hi);
        chk({tag, " lo"},    dif.lo_o, exp_lo);
    endtask

    initial begin
        dif.ex_is_div      = 1'b0;
        dif.ex_is_sign_div = 1'b0;
        dif.ex_src0        = '0;
        dif.ex_src1        = '0;
        dif.irq            = 1'b0;
        dif.stall_other    = 1'b0;
        #1;
        chk("rst stall", 32'(dif.stall_div), 32'd0);
        chk("rst busy",  32'(dif.busy), 32'd0);
        chk("rst we",    32'(dif.hilo_we), 32'd0);
        chk("rst hi",    dif.hi_o, 32'd0);
        chk("rst lo",    dif.lo_o, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_div("divu100_7",  1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 34, 0, 1'b1);
        run_div("div-7_2",    1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 0, 1'b1);
        run_div("div7_-2",    1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 34, 0, 1'b1);
        run_div("div_min_-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 34, 0, 1'b1);
        run_div("div-100_-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14, 34, 0, 1'b1);
        run_div("divu_big",   1'b0, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, 34, 0, 1'b1);
        run_div("divu5_0",    1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1, 0, 1'b1);
        run_div("div-5_0",    1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1, 0, 1'b1);

        // irq at RUN cnt=10 (cycle 11 after detect)
        dif.ex_is_div = 1'b1; dif.ex_is_sign_div = 1'b0;
        dif.ex_src0 = 32'd1000; dif.ex_src1 = 32'd3;
        repeat (10) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("irq pre stall", 32'(dif.stall_div), 32'd1);
        chk("irq pre busy",  32'(dif.busy), 32'd1);
        @(posedge clk); #1;
        dif.irq = 1'b1;
        @(negedge clk);
        chk("irq stall", 32'(dif.stall_div), 32'd0);
        chk("irq we",    32'(dif.hilo_we), 32'd0);
        @(posedge clk); #1;
        dif.irq = 1'b0; dif.ex_is_div = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk("irq post busy", 32'(dif.busy), 32'd0);
            chk("irq post we",   32'(dif.hilo_we), 32'd0);
            @(posedge clk); #1;
            if (c >= 1) break;
        end
        chk("irq hi kept", dif.hi_o, 32'hFFFF_FFFB);
        chk("irq lo kept", dif.lo_o, 32'hFFFF_FFFF);
        run_div("after_irq", 1'b0, 32'd1000, 32'd3, 32'd1, 32'd333, 34, 0, 1'b1);

        // irq together with a new divide in IDLE: no start
        dif.ex_is_div = 1'b1; dif.irq = 1'b1;
        @(negedge clk);
        chk("irq_idle stall", 32'(dif.stall_div), 32'd0);
        @(posedge clk); #1;
        dif.ex_is_div = 1'b0; dif.irq = 1'b0;
        @(negedge clk);
        chk("irq_idle busy", 32'(dif.busy), 32'd0);
        @(posedge clk); #1;

        // DONE held by stall_other, then back-to-back divides
        run_div("hold",  1'b0, 32'd50, 32'd6, 32'd2, 32'd8, 34, 3, 1'b1);
        run_div("b2b_a", 1'b0, 32'd81, 32'd9, 32'd0, 32'd9, 34, 0, 1'b0);
        run_div("b2b_b", 1'b1, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFA, 34, 0, 1'b1);

        // async reset in the middle of RUN
        dif.ex_is_div = 1'b1; dif.ex_is_sign_div = 1'b0;
        dif.ex_src0 = 32'd77; dif.ex_src1 = 32'd5;
        repeat (6) begin @(posedge clk); #1; end
        dif.ex_is_div = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("arst busy",  32'(dif.busy), 32'd0);
        chk("arst stall", 32'(dif.stall_div), 32'd0);
        chk("arst we",    32'(dif.hilo_we), 32'd0);
        chk("arst hi",    dif.hi_o, 32'd0);
        chk("arst lo",    dif.lo_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_div("post_rst", 1'b0, 32'd77, 32'd5, 32'd2, 32'd15, 34, 0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
